div_seq: RTL

Iterative 32-bit integer divider for the structural ALU, producing quotient and remainder by repeated subtract-and-test: one shift/subtract/sign-check step per cycle, the sequential counterpart to the combinational set-less-than path. It sits beside the combinational ALU as a multi-cycle functional unit. It is driven by a start/busy/done handshake from the issue logic. Signed and unsigned division are selected per operation.

---
 rtl/div_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: iterative restoring 32-bit signed/unsigned divider with start/busy/done handshake
// Ports:
//   i_clk, i_rst_n          rising-edge clock, asynchronous active-low reset
//   i_start                 request, sampled only while idle
//   i_is_signed             1 = two's-complement operands, captured with i_start
//   i_dividend, i_divisor   operands, captured with i_start
//   o_busy                  high while an operation is in flight
//   o_done                  one-cycle pulse when results update
//   o_quotient, o_remainder registered results, held until the next o_done
//   o_div_by_zero           registered flag, updated with o_done
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_a, r_quotient, r_remainder;
    logic             r_sa, r_sb, r_done, r_dz;
    logic             w_neg_a, w_neg_b, w_zero;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_trial;
    assign w_neg_a = i_is_signed & i_dividend[WIDTH-1];
    assign w_neg_b = i_is_signed & i_divisor[WIDTH-1];
    // negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude
    assign w_abs_a = w_neg_a ? -i_dividend : i_dividend;
    assign w_abs_b = w_neg_b ? -i_divisor : i_divisor;
    // the shifted partial remainder needs WIDTH+1 bits so an unsigned divisor near 2^WIDTH still compares correctly
    assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign w_zero  = r_dvs == '0;
    assign w_q_fix = w_zero ? '1 : (r_sa ^ r_sb) ? -r_quo : r_quo;
    assign w_r_fix = w_zero ? r_a : r_sa ? -r_rem : r_rem;
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && i_start) w_next = RUN;
        else if (r_state == RUN && r_cnt == CW'(WIDTH - 1)) w_next = FIX;
        else if (r_state == FIX) w_next = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_a         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_done      <= 1'b0;
            r_dz        <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && i_start) begin
                r_sa  <= w_neg_a;
                r_sb  <= w_neg_b;
                r_dvs <= w_abs_b;
                r_quo <= w_abs_a;
                r_a   <= i_dividend;
                r_rem <= '0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                // restoring step: keep the shifted remainder when the trial subtraction goes negative
                r_rem <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == FIX) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
                r_dz        <= w_zero;
                r_done      <= 1'b1;
            end
        end
    end
    assign o_busy        = r_state != IDLE;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dz;
endmodule
